// File: rtl/serial_tx_param.sv
// serial_tx_param: parametrised UART transmitter (start, DATA_W bits LSB first, optional parity, 1-2 stops).
// Latency: word accepted at edge T drives the start bit from T+1; frame lasts (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: READY only in IDLE or the last stop-bit cycle; VALID while READY=0 is dropped, not queued.
// Optional feature: define SERIAL_TX_PARITY_EN to insert a parity bit (polarity from PARITY_ODD).
module serial_tx_param #(
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              CLK_TX,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  // Bit-period counter: at least one bit wide so CLKS_PER_BIT=1 still elaborates.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Bit index covers up to 9 data bits.
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic       PAR_INV   = (PARITY_ODD != 0);
`endif

  // Reject illegal configurations at elaboration rather than shipping a broken frame format.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("serial_tx_param: DATA_W must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("serial_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("serial_tx_param: CLKS_PER_BIT must be at least 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("serial_tx_param: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              bit_end;
  logic              last_stop;
  logic              accept;
  logic              tx_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_bit;
`endif

  assign bit_end   = (cnt == CNT_LAST);
  assign last_stop = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);

  // Accepting in the final stop cycle lets the next start bit abut the stop bit.
  assign READY  = RST && ((state == ST_IDLE) || last_stop);
  assign accept = VALID && READY;
  assign DONE   = RST && last_stop;
  assign BUSY   = (state != ST_IDLE);
  assign TX     = tx_bit;

  // Bit-period counter: restarts on accept, idles at zero, wraps at each bit boundary.
  always_ff @(posedge CLK_TX) begin
    if (!RST) begin
      cnt <= '0;
    end else if (accept || (state == ST_IDLE) || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame sequencer: state, bit index and data shift register advance on bit boundaries.
  always_ff @(posedge CLK_TX) begin
    if (!RST) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shift   <= '0;
    end else if (accept) begin
      state   <= ST_START;
      bit_idx <= '0;
      shift   <= DATA;
    end else if (bit_end) begin
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          bit_idx <= '0;
        end
        ST_DATA: begin
          shift <= shift >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
            state   <= ST_PARITY;
`else
            state   <= ST_STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          state   <= ST_STOP;
          bit_idx <= '0;
        end
`endif
        ST_STOP: begin
          // Back-to-back accept is handled above; here the frame simply ends.
          if (bit_idx == STOP_LAST) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          bit_idx <= '0;
        end
      endcase
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is fixed at accept time, since the shift register is consumed during the data bits.
  always_ff @(posedge CLK_TX) begin
    if (!RST) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= (^DATA) ^ PAR_INV;
    end
  end
`endif

  // Line driver: decode of registered state, idles high.
  always_comb begin
    tx_bit = 1'b1;
    case (state)
      ST_START:  tx_bit = 1'b0;
      ST_DATA:   tx_bit = shift[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_bit = par_bit;
`endif
      default:   tx_bit = 1'b1;
    endcase
  end

endmodule
